coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
- Front-end stage for the drink vending FSM.
- Takes three raw, bouncy coin-sensor lines (nickel, dime, quarter), synchronises and debounces each, and latches one pending coin per denomination.
- Serialises pending coins into registered, single-cycle, one-hot n/d/q pulses. The drink FSM never sees two coins in one cycle and always sees at least one idle cycle between coins.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles the synchronised input must differ from the debounced level before that level flips. Legal range 1..(2**CNT_W)-1.
- CNT_W, 3: width of each debounce counter.

Ports:
- clk  input  1  system clock; all flops on rising edge.
- reset  input  1  synchronous, active-high reset.
- coin_n_raw  input  1  raw nickel sensor (5), asynchronous.
- coin_d_raw  input  1  raw dime sensor (10), asynchronous.
- coin_q_raw  input  1  raw quarter sensor (25), asynchronous.
- inhibit  input  1  while high, no new pulse is granted; pending coins are held.
- n  output  1  one-cycle nickel pulse to drink FSM.
- d  output  1  one-cycle dime pulse.
- q  output  1  one-cycle quarter pulse.
- pending  output  3  {q,d,n} latched-but-not-yet-emitted coins.
- overrun  output  1  sticky error flag: a coin was lost.

Behaviour:
- Reset (synchronous, active-high, clk): clears all sync flops, debounced levels, counters, pending, overrun and n/d/q to 0. State goes to IDLE.
- Reset mid-operation: in-flight debounce and pending coins are discarded. A raw line held high through reset is treated as a new coin after reset deasserts.
- Per channel, synchroniser: two-flop chain sync1 -> sync2.
- Per channel, debounce:
  - deb is the debounced level.
  - When sync2 == deb, cnt clears to 0.
  - When sync2 != deb and cnt < DEBOUNCE_CYCLES-1, cnt increments.
  - When sync2 != deb and cnt == DEBOUNCE_CYCLES-1, deb takes sync2 and cnt clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- Rise event: asserted on the edge where deb goes 0 -> 1. Falls of deb are ignored.
- Rise event, pending bit clear: sets the pending bit for that channel.
- Rise event, pending bit already set: the pending bit stays 1 and overrun is set to 1. overrun clears only on reset.
- Arbiter FSM, two states, n/d/q registered:
  - IDLE, pending != 0 and inhibit == 0: grant the highest-priority pending channel (priority q > d > n). On that edge, the granted output goes 1 and its pending bit clears. Go to GAP.
  - IDLE, otherwise: all outputs 0; stay in IDLE.
  - GAP: all outputs 0 on entry; return to IDLE unconditionally. This guarantees at least one zero cycle between pulses.
- Pulse timing: each pulse is exactly one cycle; at most one of n/d/q is high in any cycle. Consecutive grants give the pattern pulse, 0, pulse.
- Simultaneous rise event and grant on the same channel: the grant clears the old pending bit and the rise event sets it again. Net pending = 1, no overrun.
- inhibit is sampled only in IDLE. It never truncates a pulse already granted.
- Latency with IDLE, no inhibit and an empty queue: count the first edge that samples raw high as edge 1. The pulse is high after edge DEBOUNCE_CYCLES+3 (edge 7 at the default).

Decomposition:
- Package coin_pkg holds:
  - channel index constants: CH_N=0, CH_D=1, CH_Q=2;
  - arbiter state encoding: IDLE, GAP;
  - NUM_CH=3.
- Sub-module coin_debounce (sync chain, counter, deb, rise output) is instantiated once per channel. The top level holds pending, overrun and the arbiter.

Test Plan:
- Reset, then coin_n_raw held high for 10 cycles -> n high for exactly one cycle after edge 7; pending returns to 000; overrun stays 0.
- coin_d_raw high for 3 cycles, then low -> no pulse on any output; pending stays 000.
- coin_q_raw bouncing 1,0,1,0 then steady 1 -> exactly one q pulse, 4 cycles after the steady level is synchronised.
- All three raw lines rise on the same cycle -> pulses q, d, n in that order, each separated by exactly one zero cycle; pending goes 111 -> 011 -> 001 -> 000.
- inhibit=1 while two nickel rises are debounced -> one n pulse is never emitted, pending=001, overrun=1; after inhibit=0 the single n pulse appears.
- reset asserted for one cycle while pending=010 -> no d pulse; pending, overrun and outputs are all 0 after the reset edge.

Source files
------------

// File: rtl/coin_pkg.sv
// rtl/coin_pkg.sv - shared channel indices and arbiter state type for the coin acceptor
package coin_pkg;

  localparam int NUM_CH = 3;

  localparam int CH_N = 0;
  localparam int CH_D = 1;
  localparam int CH_Q = 2;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/coin_acceptor_if.sv
// rtl/coin_acceptor_if.sv - coin sensor inputs and drink-FSM pulse outputs
interface coin_acceptor_if;

  logic       coin_n_raw;
  logic       coin_d_raw;
  logic       coin_q_raw;
  logic       inhibit;
  logic       n;
  logic       d;
  logic       q;
  logic [2:0] pending;
  logic       overrun;

  modport master (
    output coin_n_raw, coin_d_raw, coin_q_raw, inhibit,
    input  n, d, q, pending, overrun
  );

  modport slave (
    input  coin_n_raw, coin_d_raw, coin_q_raw, inhibit,
    output n, d, q, pending, overrun
  );

endinterface

// File: rtl/coin_debounce.sv
// rtl/coin_debounce.sv - per-channel two-flop synchroniser, counting debouncer and rise detect
// rise_o is combinational so the pending latch sets on the same edge deb flips high.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             deb_q;
  logic             deb_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign rise_o = deb_d & ~deb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - debounced coin latching and serialised one-hot n/d/q pulse arbiter
// Priority q > d > n; a GAP state forces one idle cycle between consecutive pulses.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic            clk,
  input  logic            reset,
  coin_acceptor_if.slave  bus
);

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] pending_q;
  logic [NUM_CH-1:0] pending_d;
  logic [NUM_CH-1:0] pulse_q;
  logic              overrun_q;
  logic              overrun_d;
  arb_state_e        state_q;

  assign raw = {bus.coin_q_raw, bus.coin_d_raw, bus.coin_n_raw};

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_deb
    coin_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (raw[ch]),
      .rise_o (rise[ch])
    );
  end

  always_comb begin
    grant = '0;
    if (state_q == IDLE && !bus.inhibit) begin
      if (pending_q[CH_Q]) begin
        grant[CH_Q] = 1'b1;
      end else if (pending_q[CH_D]) begin
        grant[CH_D] = 1'b1;
      end else if (pending_q[CH_N]) begin
        grant[CH_N] = 1'b1;
      end
    end
  end

  // A rise on a channel being granted this edge re-arms it without counting as lost.
  assign pending_d = (pending_q & ~grant) | rise;
  assign overrun_d = overrun_q | (|(rise & pending_q & ~grant));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pulse_q   <= '0;
      pending_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      case (state_q)
        IDLE: begin
          pulse_q <= grant;
          if (|grant) begin
            state_q <= GAP;
          end
        end
        GAP: begin
          pulse_q <= '0;
          state_q <= IDLE;
        end
        default: begin
          pulse_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.n       = pulse_q[CH_N];
  assign bus.d       = pulse_q[CH_D];
  assign bus.q       = pulse_q[CH_Q];
  assign bus.pending = pending_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - self-checking bench for coin_acceptor against a behavioural model
module tb_coin_acceptor;

  localparam int DC = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  coin_acceptor_if bus ();

  coin_acceptor #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: raw seen two edges late; level flips after DC consecutive disagreeing samples.
  logic [2:0] m_s1, m_s2, m_deb, m_pend, m_out;
  int         m_run[3];
  logic       m_ovr, m_gap;

  task automatic model_edge();
    logic [2:0] raw, rise, g;
    logic       old;
    raw = {bus.coin_q_raw, bus.coin_d_raw, bus.coin_n_raw};
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_pend = '0; m_out = '0;
      m_ovr = 1'b0; m_gap = 1'b0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
      return;
    end
    rise = '0;
    for (int i = 0; i < 3; i++) begin
      old = m_s2[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
      if (old != m_deb[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DC) begin
          m_deb[i] = old;
          m_run[i] = 0;
          rise[i] = old;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    g = '0;
    if (!m_gap && !bus.inhibit) begin
      if (m_pend[2]) g = 3'b100;
      else if (m_pend[1]) g = 3'b010;
      else if (m_pend[0]) g = 3'b001;
    end
    m_ovr = m_ovr | (|(rise & m_pend & ~g));
    m_pend = (m_pend & ~g) | rise;
    m_gap = |g;
    m_out = g;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    bus.coin_n_raw = 1'b0; bus.coin_d_raw = 1'b0; bus.coin_q_raw = 1'b0;
    bus.inhibit = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({bus.q, bus.d, bus.n} !== 3'b000 || bus.pending !== 3'b000 || bus.overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state got qdn=%b pend=%b ovr=%b exp 000/000/0",
               {bus.q, bus.d, bus.n}, bus.pending, bus.overrun);
    end
  endtask

  task automatic test_single_nickel();
    int pulses = 0;
    int at = -1;
    do_reset();
    bus.coin_n_raw = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 10) bus.coin_n_raw = 1'b0;
      if (bus.n) begin pulses++; at = e; end
      n_cmp++;
      if ({bus.q, bus.d, bus.n} !== m_out || bus.pending !== m_pend || bus.overrun !== m_ovr) begin
        n_bad++;
        $display("FAIL nickel_model e=%0d got qdn=%b pend=%b ovr=%b exp qdn=%b pend=%b ovr=%b",
                 e, {bus.q, bus.d, bus.n}, bus.pending, bus.overrun, m_out, m_pend, m_ovr);
      end
    end
    n_cmp++;
    if (pulses !== 1 || at !== 7) begin
      n_bad++;
      $display("FAIL nickel_latency got pulses=%0d at edge %0d exp 1 at edge 7", pulses, at);
    end
    n_cmp++;
    if (bus.pending !== 3'b000 || bus.overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL nickel_after got pend=%b ovr=%b exp 000/0", bus.pending, bus.overrun);
    end
  endtask

  task automatic test_glitch();
    int bad = 0;
    do_reset();
    bus.coin_d_raw = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e == 3) bus.coin_d_raw = 1'b0;
      if ({bus.q, bus.d, bus.n} != 3'b000 || bus.pending != 3'b000) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL glitch got %0d cycles with pulse/pending exp 0", bad);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    int pulses = 0;
    int at = -1;
    pat = 4'b0101;
    do_reset();
    bus.coin_q_raw = pat[0];
    for (int e = 1; e <= 18; e++) begin
      tick();
      bus.coin_q_raw = (e < 4) ? pat[e] : 1'b1;
      if (bus.q) begin pulses++; at = e; end
      n_cmp++;
      if ({bus.q, bus.d, bus.n} !== m_out || bus.pending !== m_pend || bus.overrun !== m_ovr) begin
        n_bad++;
        $display("FAIL bounce_model e=%0d got qdn=%b pend=%b exp qdn=%b pend=%b",
                 e, {bus.q, bus.d, bus.n}, bus.pending, m_out, m_pend);
      end
    end
    n_cmp++;
    if (pulses !== 1 || at !== 11) begin
      n_bad++;
      $display("FAIL bounce_pulse got pulses=%0d at edge %0d exp 1 at edge 11", pulses, at);
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp_out [16];
    logic [2:0] exp_pend [16];
    for (int e = 0; e < 16; e++) begin
      exp_out[e] = 3'b000;
      exp_pend[e] = (e < 6) ? 3'b000 : (e < 7) ? 3'b111 : (e < 9) ? 3'b011 : (e < 11) ? 3'b001 : 3'b000;
    end
    exp_out[7] = 3'b100; exp_out[9] = 3'b010; exp_out[11] = 3'b001;
    do_reset();
    bus.coin_n_raw = 1'b1; bus.coin_d_raw = 1'b1; bus.coin_q_raw = 1'b1;
    for (int e = 1; e < 16; e++) begin
      tick();
      if (e == 10) begin
        bus.coin_n_raw = 1'b0; bus.coin_d_raw = 1'b0; bus.coin_q_raw = 1'b0;
      end
      n_cmp++;
      if ({bus.q, bus.d, bus.n} !== exp_out[e] || bus.pending !== exp_pend[e] || bus.overrun !== 1'b0) begin
        n_bad++;
        $display("FAIL simultaneous e=%0d got qdn=%b pend=%b ovr=%b exp qdn=%b pend=%b ovr=0",
                 e, {bus.q, bus.d, bus.n}, bus.pending, bus.overrun, exp_out[e], exp_pend[e]);
      end
    end
  endtask

  task automatic test_inhibit_overrun();
    int pulses = 0;
    do_reset();
    bus.inhibit = 1'b1;
    for (int e = 0; e < 34; e++) begin
      bus.coin_n_raw = (e < 8) || (e >= 16 && e < 24);
      tick();
      if (bus.n || bus.d || bus.q) pulses++;
    end
    n_cmp++;
    if (pulses !== 0 || bus.pending !== 3'b001 || bus.overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL inhibit_hold got pulses=%0d pend=%b ovr=%b exp 0/001/1",
               pulses, bus.pending, bus.overrun);
    end
    bus.inhibit = 1'b0;
    for (int e = 0; e < 6; e++) begin
      tick();
      if (bus.n) pulses++;
    end
    n_cmp++;
    if (pulses !== 1 || bus.pending !== 3'b000 || bus.overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL inhibit_release got n_pulses=%0d pend=%b ovr=%b exp 1/000/1",
               pulses, bus.pending, bus.overrun);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    do_reset();
    bus.inhibit = 1'b1;
    bus.coin_d_raw = 1'b1;
    for (int e = 0; e < 8; e++) tick();
    bus.coin_d_raw = 1'b0;
    n_cmp++;
    if (bus.pending !== 3'b010) begin
      n_bad++;
      $display("FAIL reset_mid_setup got pend=%b exp 010", bus.pending);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.inhibit = 1'b0;
    n_cmp++;
    if ({bus.q, bus.d, bus.n} !== 3'b000 || bus.pending !== 3'b000 || bus.overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_clear got qdn=%b pend=%b ovr=%b exp 000/000/0",
               {bus.q, bus.d, bus.n}, bus.pending, bus.overrun);
    end
    for (int e = 0; e < 14; e++) begin
      tick();
      if (bus.d) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_no_pulse got d_pulses=%0d exp 0", pulses);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    int multi = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(5) == 0) bus.coin_n_raw = ~bus.coin_n_raw;
      if ($urandom_range(5) == 0) bus.coin_d_raw = ~bus.coin_d_raw;
      if ($urandom_range(5) == 0) bus.coin_q_raw = ~bus.coin_q_raw;
      if ($urandom_range(7) == 0) bus.inhibit = ~bus.inhibit;
      reset = ($urandom_range(399) == 0);
      tick();
      n_cmp++;
      if ({bus.q, bus.d, bus.n} !== m_out || bus.pending !== m_pend || bus.overrun !== m_ovr) begin
        n_bad++;
        bad++;
        if (bad <= 10)
          $display("FAIL random c=%0d got qdn=%b pend=%b ovr=%b exp qdn=%b pend=%b ovr=%b",
                   c, {bus.q, bus.d, bus.n}, bus.pending, bus.overrun, m_out, m_pend, m_ovr);
      end
      if (($countones({bus.q, bus.d, bus.n})) > 1) multi++;
    end
    reset = 1'b0;
    n_cmp++;
    if (multi !== 0) begin
      n_bad++;
      $display("FAIL random_onehot got %0d multi-hot cycles exp 0", multi);
    end
  endtask

  initial begin
    bus.coin_n_raw = 1'b0; bus.coin_d_raw = 1'b0; bus.coin_q_raw = 1'b0;
    bus.inhibit = 1'b0;
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_pend = '0; m_out = '0;
    m_ovr = 1'b0; m_gap = 1'b0;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    test_reset();
    test_single_nickel();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_inhibit_overrun();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
